// File: rtl/cam_frame_writer_pkg.sv
// cam_frame_writer_pkg
//   Types and constants shared by the camera capture path and the VGA reader.
//   - Frame geometry of the 320x240 buffer and the 2x VGA upscale.
//   - RGB565 byte-pair to RGB444 bit-slice positions.
//   - Capture FSM state encoding.
//   No ports.
package cam_frame_writer_pkg;

   // Frame buffer geometry; the VGA controller scales it by VGA_SCALE.
   localparam int unsigned H_PIX_DEF    = 320;
   localparam int unsigned V_PIX_DEF    = 240;
   localparam int unsigned FRAME_PIXELS = H_PIX_DEF * V_PIX_DEF;
   localparam int unsigned VGA_SCALE    = 2;
   localparam int unsigned VGA_H_PIX    = H_PIX_DEF * VGA_SCALE;
   localparam int unsigned VGA_V_PIX    = V_PIX_DEF * VGA_SCALE;
   localparam int unsigned ADDR_W_DEF   = 19;

   // RGB565 arrives as hi = {R[4:0], G[5:3]}, lo = {G[2:0], B[4:0]}.
   // The top 4 bits of each channel are kept.
   localparam int unsigned HI_R_MSB = 7;
   localparam int unsigned HI_R_LSB = 4;
   localparam int unsigned HI_G_MSB = 2;
   localparam int unsigned HI_G_LSB = 0;
   localparam int unsigned LO_G_BIT = 7;
   localparam int unsigned LO_B_MSB = 4;
   localparam int unsigned LO_B_LSB = 1;
   // Bits of the hi byte that are retained: {R[3:0], G[3:1]}.
   localparam int unsigned HI_KEEP_W = 7;

   typedef enum logic [1:0] {
      S_SYNC    = 2'd0,
      S_BLANK   = 2'd1,
      S_CAPTURE = 2'd2
   } state_e;

   function automatic logic [11:0] pack_rgb444(input logic [3:0] r,
                                               input logic [3:0] g,
                                               input logic [3:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/cam_frame_writer_if.sv
// cam_frame_writer_if
//   Bundles the camera stream, the capture enable, the BRAM write port and
//   the frame status signals of cam_frame_writer.
//   slave  : view of the capture block (consumes camera, drives BRAM/status).
//   master : view of the surrounding system (drives camera, consumes BRAM/status).
interface cam_frame_writer_if
   import cam_frame_writer_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

   logic              cam_vsync;
   logic              cam_href;
   logic [7:0]        cam_data;
   logic              capture_en;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;
   logic              frame_done;
   logic              frame_err;
   logic              busy;

   modport slave (
      input  cam_vsync, cam_href, cam_data, capture_en,
      output wr_en, wr_addr, wr_data, frame_done, frame_err, busy
   );

   modport master (
      output cam_vsync, cam_href, cam_data, capture_en,
      input  wr_en, wr_addr, wr_data, frame_done, frame_err, busy
   );

endinterface

// File: rtl/cam_sync_edge.sv
// cam_sync_edge
//   Registers the camera inputs once and detects edges of the active level
//   of vsync.
//   clk25, rstn_clk25 : clock, asynchronous active-low reset
//   vsync_i, href_i, data_i, cap_en_i : raw inputs
//   href_o, data_o, cap_en_o : registered copies
//   vs_rise_o, vs_fall_o : single-cycle edges of the active vsync level
module cam_sync_edge
   import cam_frame_writer_pkg::*;
#(
   parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
   input  logic       clk25,
   input  logic       rstn_clk25,
   input  logic       vsync_i,
   input  logic       href_i,
   input  logic [7:0] data_i,
   input  logic       cap_en_i,
   output logic       href_o,
   output logic [7:0] data_o,
   output logic       cap_en_o,
   output logic       vs_rise_o,
   output logic       vs_fall_o
);

   logic       vs_act_q;
   logic       vs_prev_q;
   logic       href_q;
   logic [7:0] data_q;
   logic       cap_en_q;

   // vs_act is normalised so that 1 always means vertical blanking.
   always_ff @(posedge clk25 or negedge rstn_clk25) begin
      if (!rstn_clk25) begin
         vs_act_q  <= 1'b0;
         vs_prev_q <= 1'b0;
         href_q    <= 1'b0;
         data_q    <= 8'h00;
         cap_en_q  <= 1'b0;
      end else begin
         vs_act_q  <= vsync_i ~^ VSYNC_ACTIVE_HIGH;
         vs_prev_q <= vs_act_q;
         href_q    <= href_i;
         data_q    <= data_i;
         cap_en_q  <= cap_en_i;
      end
   end

   assign href_o    = href_q;
   assign data_o    = data_q;
   assign cap_en_o  = cap_en_q;
   assign vs_rise_o = vs_act_q & ~vs_prev_q;
   assign vs_fall_o = ~vs_act_q & vs_prev_q;

endmodule

// File: rtl/cam_frame_writer.sv
// cam_frame_writer
//   Captures an 8-bit RGB565 camera stream (two bytes per pixel, vsync/href
//   framing) into a H_PIX x V_PIX RGB444 frame buffer, writing addresses
//   0..H_PIX*V_PIX-1 in order. Whole frames are gated by capture_en, which is
//   sampled only at the start of the active frame.
//   clk25, rstn_clk25 : clock, asynchronous active-low reset
//   bus (slave)       : camera inputs, capture_en, BRAM write port
//                       (wr_en/wr_addr/wr_data), frame_done, frame_err, busy
module cam_frame_writer
   import cam_frame_writer_pkg::*;
#(
   parameter int unsigned H_PIX             = H_PIX_DEF,
   parameter int unsigned V_PIX             = V_PIX_DEF,
   parameter int unsigned ADDR_W            = ADDR_W_DEF,
   parameter bit          VSYNC_ACTIVE_HIGH = 1'b1
) (
   input  logic              clk25,
   input  logic              rstn_clk25,
   cam_frame_writer_if.slave bus
);

   localparam logic [ADDR_W-1:0] FRAME_CNT = ADDR_W'(H_PIX * V_PIX);

   logic       href;
   logic [7:0] data;
   logic       cap_en;
   logic       vs_rise;
   logic       vs_fall;

   cam_sync_edge #(
      .VSYNC_ACTIVE_HIGH(VSYNC_ACTIVE_HIGH)
   ) u_sync (
      .clk25     (clk25),
      .rstn_clk25(rstn_clk25),
      .vsync_i   (bus.cam_vsync),
      .href_i    (bus.cam_href),
      .data_i    (bus.cam_data),
      .cap_en_i  (bus.capture_en),
      .href_o    (href),
      .data_o    (data),
      .cap_en_o  (cap_en),
      .vs_rise_o (vs_rise),
      .vs_fall_o (vs_fall)
   );

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      pix_cnt_q, pix_cnt_d;
   logic                   phase_q, phase_d;
   logic [HI_KEEP_W-1:0]   hi_q, hi_d;
   logic                   ovf_q, ovf_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic [11:0]            wr_data_q, wr_data_d;
   logic                   frame_done_q, frame_done_d;
   logic                   frame_err_q, frame_err_d;

   always_comb begin
      state_d      = state_q;
      pix_cnt_d    = pix_cnt_q;
      phase_d      = phase_q;
      hi_d         = hi_q;
      ovf_d        = ovf_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;

      unique case (state_q)
         // Wait for a clean frame boundary so a partial frame is never stored.
         S_SYNC: begin
            phase_d = 1'b0;
            if (vs_rise) begin
               state_d = S_BLANK;
            end
         end

         S_BLANK: begin
            phase_d = 1'b0;
            if (vs_fall && cap_en) begin
               pix_cnt_d = '0;
               ovf_d     = 1'b0;
               state_d   = S_CAPTURE;
            end
         end

         S_CAPTURE: begin
            if (href) begin
               phase_d = ~phase_q;
               if (!phase_q) begin
                  hi_d = {data[HI_R_MSB:HI_R_LSB], data[HI_G_MSB:HI_G_LSB]};
               end else if (pix_cnt_q < FRAME_CNT) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = pix_cnt_q;
                  wr_data_d = pack_rgb444(hi_q[6:3], {hi_q[2:0], data[LO_G_BIT]},
                                          data[LO_B_MSB:LO_B_LSB]);
                  pix_cnt_d = pix_cnt_q + ADDR_W'(1);
               end else begin
                  // Frame too long: hold the address, remember the overrun.
                  ovf_d = 1'b1;
               end
            end else begin
               // An odd trailing byte on a line is discarded.
               phase_d = 1'b0;
            end

            // A pixel completing in this cycle is still counted above.
            if (vs_rise) begin
               state_d      = S_BLANK;
               frame_done_d = 1'b1;
               frame_err_d  = (pix_cnt_d != FRAME_CNT) | ovf_d;
            end
         end

         default: begin
            state_d = S_SYNC;
         end
      endcase
   end

   always_ff @(posedge clk25 or negedge rstn_clk25) begin
      if (!rstn_clk25) begin
         state_q      <= S_SYNC;
         pix_cnt_q    <= '0;
         phase_q      <= 1'b0;
         hi_q         <= '0;
         ovf_q        <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 12'h000;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_cnt_q    <= pix_cnt_d;
         phase_q      <= phase_d;
         hi_q         <= hi_d;
         ovf_q        <= ovf_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = (state_q == S_CAPTURE);

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer
//   Directed bench for cam_frame_writer on a reduced 4x3 frame (12 pixels).
//   A negedge monitor checks every BRAM write against the expected address
//   and pixel; the main sequence checks counts, status and latency.
module tb_cam_frame_writer;

   localparam int unsigned HP    = 4;
   localparam int unsigned VP    = 3;
   localparam int unsigned AW    = 19;
   localparam int          NPIX  = HP * VP;

   logic clk25;
   logic rstn_clk25;

   cam_frame_writer_if #(.ADDR_W(AW)) bus ();

   cam_frame_writer #(
      .H_PIX            (HP),
      .V_PIX            (VP),
      .ADDR_W           (AW),
      .VSYNC_ACTIVE_HIGH(1'b1)
   ) dut (
      .clk25     (clk25),
      .rstn_clk25(rstn_clk25),
      .bus       (bus)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          exp_addr = 0;
   int          last_addr = -1;
   logic [11:0] exp_data = 12'h000;

   initial begin
      clk25 = 1'b0;
      forever #20 clk25 = ~clk25;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Write monitor: every write must land at the next expected address.
   initial begin
      forever begin
         @(negedge clk25);
         if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            chk("wr_addr", 32'(bus.wr_addr), exp_addr);
            chk("wr_data", 32'(bus.wr_data), 32'(exp_data));
            last_addr = int'(bus.wr_addr);
            exp_addr++;
         end
         if (bus.frame_done === 1'b1) done_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk25);
   endtask

   task automatic vs_pulse();
      @(negedge clk25);
      bus.cam_vsync = 1'b1;
      tick(3);
      bus.cam_vsync = 1'b0;
      tick(4);
   endtask

   task automatic send_line(input int npix, input bit odd);
      for (int i = 0; i < npix; i++) begin
         @(negedge clk25);
         bus.cam_href = 1'b1;
         bus.cam_data = 8'hF8;
         @(negedge clk25);
         bus.cam_data = 8'h00;
      end
      if (odd) begin
         @(negedge clk25);
         bus.cam_data = 8'hF8;
      end
      @(negedge clk25);
      bus.cam_href = 1'b0;
      bus.cam_data = 8'h00;
      tick(2);
   endtask

   task automatic send_frame(input int nlines, input bit odd);
      exp_data = 12'hF00;
      for (int l = 0; l < nlines; l++) send_line(HP, odd);
   endtask

   // One pixel with exact wr_en timing: high only 2 cycles after the lo byte.
   task automatic send_pixel_lat(input logic [7:0] hi, input logic [7:0] lo,
                                 input logic [11:0] want);
      exp_data = want;
      @(negedge clk25);
      bus.cam_href = 1'b1;
      bus.cam_data = hi;
      @(negedge clk25);
      bus.cam_data = lo;
      @(negedge clk25);
      bus.cam_href = 1'b0;
      bus.cam_data = 8'h00;
      chk("lat_wr_en_+1", 32'(bus.wr_en), 0);
      @(negedge clk25);
      chk("lat_wr_en_+2", 32'(bus.wr_en), 1);
      chk("lat_wr_data", 32'(bus.wr_data), 32'(want));
      @(negedge clk25);
      chk("lat_wr_en_+3", 32'(bus.wr_en), 0);
   endtask

   int w0;
   int d0;

   initial begin
      rstn_clk25     = 1'b0;
      bus.cam_vsync  = 1'b0;
      bus.cam_href   = 1'b0;
      bus.cam_data   = 8'h00;
      bus.capture_en = 1'b1;
      tick(3);
      chk("rst_wr_en", 32'(bus.wr_en), 0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_wr_data", 32'(bus.wr_data), 0);
      chk("rst_frame_done", 32'(bus.frame_done), 0);
      chk("rst_frame_err", 32'(bus.frame_err), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      rstn_clk25 = 1'b1;
      tick(2);

      // Data before the first vsync is discarded.
      w0 = wr_cnt;
      send_frame(VP, 1'b0);
      chk("pre_sync_writes", wr_cnt - w0, 0);
      chk("pre_sync_busy", 32'(bus.busy), 0);

      // Full frame of 0xF8/0x00 -> 0xF00 at addresses 0..11.
      vs_pulse();
      chk("cap_busy", 32'(bus.busy), 1);
      exp_addr = 0;
      w0 = wr_cnt;
      d0 = done_cnt;
      send_frame(VP, 1'b0);
      vs_pulse();
      chk("full_writes", wr_cnt - w0, NPIX);
      chk("full_last_addr", last_addr, NPIX - 1);
      chk("full_done", done_cnt - d0, 1);
      chk("full_err", 32'(bus.frame_err), 0);

      // Colour conversion and write latency.
      exp_addr = 0;
      w0 = wr_cnt;
      d0 = done_cnt;
      send_pixel_lat(8'h07, 8'hE0, 12'h0F0);
      send_pixel_lat(8'h00, 8'h1F, 12'h00F);
      exp_data = 12'hF00;
      send_line(4, 1'b0);
      send_line(4, 1'b0);
      send_line(2, 1'b0);
      bus.capture_en = 1'b0;
      vs_pulse();
      chk("color_writes", wr_cnt - w0, NPIX);
      chk("color_done", done_cnt - d0, 1);
      chk("color_err", 32'(bus.frame_err), 0);

      // capture_en low at frame start: frame skipped even if raised later.
      chk("skip_busy0", 32'(bus.busy), 0);
      tick(2);
      bus.capture_en = 1'b1;
      w0 = wr_cnt;
      d0 = done_cnt;
      send_frame(VP, 1'b0);
      chk("skip_busy1", 32'(bus.busy), 0);
      vs_pulse();
      chk("skip_writes", wr_cnt - w0, 0);
      chk("skip_done", done_cnt - d0, 0);
      chk("skip_resume_busy", 32'(bus.busy), 1);

      // One extra line: writes stop at the last address, error flagged.
      exp_addr = 0;
      w0 = wr_cnt;
      send_frame(VP + 1, 1'b0);
      vs_pulse();
      chk("long_writes", wr_cnt - w0, NPIX);
      chk("long_last_addr", last_addr, NPIX - 1);
      chk("long_err", 32'(bus.frame_err), 1);

      // Correct frame clears the error.
      exp_addr = 0;
      w0 = wr_cnt;
      send_frame(VP, 1'b0);
      vs_pulse();
      chk("clear_writes", wr_cnt - w0, NPIX);
      chk("clear_err", 32'(bus.frame_err), 0);

      // Odd trailing byte on every line is dropped.
      exp_addr = 0;
      w0 = wr_cnt;
      send_frame(VP, 1'b1);
      vs_pulse();
      chk("odd_writes", wr_cnt - w0, NPIX);
      chk("odd_err", 32'(bus.frame_err), 0);

      // Short frame of a single line.
      exp_addr = 0;
      w0 = wr_cnt;
      d0 = done_cnt;
      send_frame(1, 1'b0);
      vs_pulse();
      chk("short_writes", wr_cnt - w0, HP);
      chk("short_done", done_cnt - d0, 1);
      chk("short_err", 32'(bus.frame_err), 1);

      // Asynchronous reset while a write strobe is high.
      exp_addr = 0;
      exp_data = 12'hF00;
      @(negedge clk25);
      bus.cam_href = 1'b1;
      bus.cam_data = 8'hF8;
      @(negedge clk25);
      bus.cam_data = 8'h00;
      @(negedge clk25);
      bus.cam_href = 1'b0;
      @(negedge clk25);
      chk("arst_pre_wr_en", 32'(bus.wr_en), 1);
      #5;
      rstn_clk25 = 1'b0;
      #1;
      chk("arst_wr_en", 32'(bus.wr_en), 0);
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_frame_err", 32'(bus.frame_err), 0);
      tick(2);
      rstn_clk25 = 1'b1;

      // Back in sync-hunt: nothing written until a full vsync pulse.
      w0 = wr_cnt;
      send_frame(VP, 1'b0);
      chk("arst_sync_writes", wr_cnt - w0, 0);
      vs_pulse();
      exp_addr = 0;
      w0 = wr_cnt;
      d0 = done_cnt;
      send_frame(VP, 1'b0);
      vs_pulse();
      chk("arst_cap_writes", wr_cnt - w0, NPIX);
      chk("arst_cap_last", last_addr, NPIX - 1);
      chk("arst_cap_done", done_cnt - d0, 1);
      chk("arst_cap_err", 32'(bus.frame_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
